// File: rtl/alu_ip.sv
// Registered signed ALU: eight operations selected by sel, one-cycle latency, zero flag.
// Define ALU_IP_SAT_EN to saturate ADD/SUB/MUL to the signed range instead of wrapping.
module alu_ip #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       sel,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] C,
  output logic             Z
);

  // Free-running datapath: no valid/ready, every edge loads a new result.
  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_OR  = 3'd4;
  localparam logic [2:0] OP_XOR = 3'd5;
  localparam logic [2:0] OP_MAX = 3'd6;
  localparam logic [2:0] OP_MIN = 3'd7;

  logic [WIDTH-1:0] add_r;
  logic [WIDTH-1:0] sub_r;
  logic [WIDTH-1:0] mul_r;
  logic [WIDTH-1:0] nxt;
  logic             a_gt_b;

`ifdef ALU_IP_SAT_EN
  localparam logic [WIDTH-1:0] MAXV = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MINV = {1'b1, {(WIDTH-1){1'b0}}};

  logic [WIDTH:0]     add_w;
  logic [WIDTH:0]     sub_w;
  logic [2*WIDTH-1:0] mul_w;

  // One guard bit is enough to detect add/sub overflow; the multiply
  // keeps the full sign-extended product.
  assign add_w = {A[WIDTH-1], A} + {B[WIDTH-1], B};
  assign sub_w = {A[WIDTH-1], A} - {B[WIDTH-1], B};
  assign mul_w = {{WIDTH{A[WIDTH-1]}}, A} * {{WIDTH{B[WIDTH-1]}}, B};

  always_comb begin
    add_r = add_w[WIDTH-1:0];
    sub_r = sub_w[WIDTH-1:0];
    mul_r = mul_w[WIDTH-1:0];
    if (add_w[WIDTH] != add_w[WIDTH-1]) add_r = add_w[WIDTH] ? MINV : MAXV;
    if (sub_w[WIDTH] != sub_w[WIDTH-1]) sub_r = sub_w[WIDTH] ? MINV : MAXV;
    // Product fits only if the upper WIDTH+1 bits are all copies of the sign.
    if (mul_w[2*WIDTH-1:WIDTH-1] != {(WIDTH+1){mul_w[2*WIDTH-1]}})
      mul_r = mul_w[2*WIDTH-1] ? MINV : MAXV;
  end
`else
  // Low WIDTH bits are identical for signed and unsigned arithmetic.
  assign add_r = A + B;
  assign sub_r = A - B;
  assign mul_r = A * B;
`endif

  assign a_gt_b = $signed(A) > $signed(B);

  always_comb begin
    nxt = '0;
    case (sel)
      OP_ADD:  nxt = add_r;
      OP_SUB:  nxt = sub_r;
      OP_MUL:  nxt = mul_r;
      OP_AND:  nxt = A & B;
      OP_OR:   nxt = A | B;
      OP_XOR:  nxt = A ^ B;
      OP_MAX:  nxt = a_gt_b ? A : B;
      OP_MIN:  nxt = a_gt_b ? B : A;
      default: nxt = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      C <= '0;
      Z <= 1'b1;
    end else begin
      C <= nxt;
      Z <= (nxt == '0);
    end
  end

endmodule

// File: tb/tb_alu_ip.sv
// Self-checking bench for alu_ip: directed vectors plus random stimulus against a scoreboard.
// Expectations follow ALU_IP_SAT_EN in the same way as the design.
module tb_alu_ip;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic [2:0]   sel;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [W-1:0] C;
  logic         Z;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_c;
  int           n_checks;
  int           n_errors;

  alu_ip #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .sel (sel),
    .A   (A),
    .B   (B),
    .C   (C),
    .Z   (Z)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference model computed with plain integers, then clamped or wrapped.
  function automatic logic [W-1:0] model(input int s, input logic [W-1:0] a, input logic [W-1:0] b);
    int ai;
    int bi;
    int r;
    ai = $signed(a);
    bi = $signed(b);
    r  = 0;
    case (s)
      0: r = ai + bi;
      1: r = ai - bi;
      2: r = ai * bi;
      3: return a & b;
      4: return a | b;
      5: return a ^ b;
      6: return (ai >= bi) ? a : b;
      default: return (ai <= bi) ? a : b;
    endcase
`ifdef ALU_IP_SAT_EN
    if (r > (2**(W-1)) - 1) r = (2**(W-1)) - 1;
    if (r < -(2**(W-1)))    r = -(2**(W-1));
`endif
    return r[W-1:0];
  endfunction

  // Driver: apply inputs on the falling edge and record the expected result.
  task automatic drive(input logic [2:0] s, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic r, input logic [W-1:0] e);
    @(negedge clk);
    sel = s;
    A   = a;
    B   = b;
    rst = r;
    exp_q.push_back(e);
  endtask

  // Scoreboard: one result per rising edge once something is expected.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_c = exp_q.pop_front();
      check("C", {24'd0, C}, {24'd0, exp_c});
      check("Z", {31'd0, Z}, {31'd0, (exp_c == '0)});
    end
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    sel = 3'd0;
    A   = 8'd5;
    B   = 8'd3;
    repeat (2) @(posedge clk);
    #1;
    check("reset_C", {24'd0, C}, 32'd0);
    check("reset_Z", {31'd0, Z}, 32'd1);

    // First edge out of reset loads 5+3.
    drive(3'd0, 8'd5, 8'd3, 1'b0, 8'd8);

`ifdef ALU_IP_SAT_EN
    drive(3'd0, 8'd100, 8'd100, 1'b0, 8'h7F);
    drive(3'd1, 8'h80,  8'd1,   1'b0, 8'h80);
    drive(3'd2, 8'd16,  8'd16,  1'b0, 8'h7F);
`else
    drive(3'd0, 8'd100, 8'd100, 1'b0, 8'hC8);
    drive(3'd1, 8'h80,  8'd1,   1'b0, 8'h7F);
    drive(3'd2, 8'd16,  8'd16,  1'b0, 8'h00);
`endif
    drive(3'd2, 8'hFD, 8'd5,   1'b0, 8'hF1);
    drive(3'd3, 8'hF0, 8'h3C,  1'b0, 8'h30);
    drive(3'd4, 8'hF0, 8'h3C,  1'b0, 8'hFC);
    drive(3'd5, 8'hF0, 8'h3C,  1'b0, 8'hCC);
    drive(3'd5, 8'h55, 8'h55,  1'b0, 8'h00);
    drive(3'd6, 8'hFB, 8'd3,   1'b0, 8'd3);
    drive(3'd7, 8'hFB, 8'd3,   1'b0, 8'hFB);
    drive(3'd6, 8'h80, 8'h80,  1'b0, 8'h80);
    drive(3'd7, 8'h80, 8'h80,  1'b0, 8'h80);

    // Back-to-back op changes: each cycle reflects the previous edge's inputs.
    begin
      logic [W-1:0] lat_exp[8];
      lat_exp = '{8'd9, 8'd5, 8'd14, 8'd2, 8'd7, 8'd5, 8'd7, 8'd2};
      for (int i = 0; i < 8; i++) drive(i[2:0], 8'd7, 8'd2, 1'b0, lat_exp[i]);
    end

    // Reset at an edge forces zero whatever the operands are.
    drive(3'd0, 8'd100, 8'd1, 1'b1, 8'h00);
    drive(3'd0, 8'd100, 8'd1, 1'b0, 8'd101);

    // A reset pulse entirely between edges must be ignored.
    drive(3'd4, 8'h12, 8'h21, 1'b0, 8'h33);
    #1 rst = 1'b1;
    #2 rst = 1'b0;

    for (int i = 0; i < 200; i++) begin
      logic [2:0]   s;
      logic [W-1:0] a;
      logic [W-1:0] b;
      s = 3'($urandom_range(0, 7));
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 7) == 0) a = 8'h80;
      if ($urandom_range(0, 7) == 0) b = 8'h7F;
      drive(s, a, b, 1'b0, model(int'(s), a, b));
    end

    // Drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    check("drain", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
